rect_fill_engine: RTL and testbench

Pixel-stream generator sitting directly upstream of `vga_adapter` in the 160x120, 3-bit-colour display path. It accepts rectangle-fill commands over a valid/ready handshake and buffers up to two of them. It emits one pixel per clock on `x`/`y`/`color`/`plot` in raster order, clipped to the screen, ready to wire straight into the adapter's `x`/`y`/`colour`/`plot` inputs.

---
 rtl/rect_fill_if.sv | 21 ++
 rtl/rect_fill_engine.sv | 129 ++++++++++++
 tb/tb_rect_fill_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rect_fill_if.sv
// Command handshake for rect_fill_engine: one rectangle-fill request per
// valid/ready transfer.
interface rect_fill_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [7:0] cmd_w;
  logic [6:0] cmd_h;
  logic [2:0] cmd_color;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle-fill pixel generator: buffers two commands and emits one clipped
// pixel per clock in raster order for a 160x120 3-bit-colour adapter.
module rect_fill_engine #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  rect_fill_if.slave  cmd,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  color,
  output logic        plot,
  output logic        busy
);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] c;
  } cmd_t;

  typedef enum logic {IDLE, DRAW} state_t;

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [7:0] H_LIM = 8'(SCREEN_H);

  state_t     state, state_next;
  cmd_t       fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count, count_next;

  logic [7:0] x0, x_end, y_end_r;
  logic [6:0] y_end;

  cmd_t       head;
  logic       head_deg;
  logic [8:0] x_end_sum, x_end_clip;
  logic [7:0] y_end_sum, y_end_clip;
  logic       push, pop, load, last;

  assign cmd.cmd_ready = (count < 2'd2);
  assign push          = cmd.cmd_valid & cmd.cmd_ready;
  assign head          = fifo_mem[rd_ptr];
  assign y_end         = y_end_r[6:0];

  always_comb begin
    head_deg   = (head.w == 8'd0) || (head.h == 7'd0) ||
                 ({1'b0, head.x} >= W_LIM) || ({1'b0, head.y} >= H_LIM);
    x_end_sum  = {1'b0, head.x} + {1'b0, head.w} - 9'd1;
    x_end_clip = (x_end_sum > W_LIM - 9'd1) ? (W_LIM - 9'd1) : x_end_sum;
    y_end_sum  = {1'b0, head.y} + {1'b0, head.h} - 8'd1;
    y_end_clip = (y_end_sum > H_LIM - 8'd1) ? (H_LIM - 8'd1) : y_end_sum;
    last       = (x == x_end) && (y == y_end);

    // A degenerate head is only discarded from IDLE; at the end of a
    // rectangle the engine drops back to IDLE first and pops it there.
    pop = 1'b0;
    unique case (state)
      IDLE: pop = (count != 2'd0);
      DRAW: pop = last && (count != 2'd0) && !head_deg;
      default: pop = 1'b0;
    endcase
    load = pop && !head_deg;

    count_next = count + {1'b0, push} - {1'b0, pop};

    state_next = state;
    unique case (state)
      IDLE: state_next = load ? DRAW : IDLE;
      DRAW: if (last) state_next = load ? DRAW : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      x0          <= '0;
      x_end       <= '0;
      y_end_r     <= '0;
      x           <= '0;
      y           <= '0;
      color       <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{x: cmd.cmd_x, y: cmd.cmd_y, w: cmd.cmd_w,
                              h: cmd.cmd_h, c: cmd.cmd_color};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_next;
      state <= state_next;
      busy  <= (state_next == DRAW) || (count_next != 2'd0);

      // x/y/color double as the working cursor, so the pixel on the outputs
      // is always the one just stepped to.
      if (load) begin
        x       <= head.x;
        y       <= head.y;
        color   <= head.c;
        x0      <= head.x;
        x_end   <= x_end_clip[7:0];
        y_end_r <= y_end_clip;
        plot    <= 1'b1;
      end else if (state == DRAW && !last) begin
        if (x < x_end) begin
          x <= x + 8'd1;
        end else begin
          x <= x0;
          if (y < y_end) y <= y + 7'd1;
        end
        plot <= 1'b1;
      end else begin
        plot <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: expected pixels are queued when a
// command is issued and a negedge monitor pops one per plot strobe.
module tb_rect_fill_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, busy;

  always #5 clk = ~clk;

  rect_fill_if cmd_if();

  rect_fill_engine #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cmd    (cmd_if),
    .x      (x),
    .y      (y),
    .color  (color),
    .plot   (plot),
    .busy   (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int plot_cnt = 0;
  int cur_run  = 0;
  int last_run = 0;
  logic [17:0] exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [17:0] px(int xx, int yy, int c);
    logic [7:0] bx = 8'(xx);
    logic [6:0] by = 7'(yy);
    logic [2:0] bc = 3'(c);
    return {bx, by, bc};
  endfunction

  task automatic expect_rect(int rx, int ry, int rw, int rh, int c);
    int xe, ye;
    if (rw == 0 || rh == 0 || rx >= 160 || ry >= 120) return;
    xe = (rx + rw - 1 > 159) ? 159 : rx + rw - 1;
    ye = (ry + rh - 1 > 119) ? 119 : ry + rh - 1;
    for (int yy = ry; yy <= ye; yy++)
      for (int xx = rx; xx <= xe; xx++)
        exp_q.push_back(px(xx, yy, c));
  endtask

  // Monitor: every plot strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (plot) begin
      plot_cnt++;
      cur_run++;
      if (exp_q.size() == 0) check("unexpected_plot", {x, y, color}, 18'h3ffff);
      else check("pixel", {x, y, color}, exp_q.pop_front());
    end else begin
      if (cur_run != 0) last_run = cur_run;
      cur_run = 0;
    end
  end

  task automatic send(int rx, int ry, int rw, int rh, int c, bit hold);
    int t = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_x     = 8'(rx);
    cmd_if.cmd_y     = 7'(ry);
    cmd_if.cmd_w     = 8'(rw);
    cmd_if.cmd_h     = 7'(rh);
    cmd_if.cmd_color = 3'(c);
    while (!cmd_if.cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_if.cmd_ready) begin
      check("send_ready_timeout", {31'd0, cmd_if.cmd_ready}, 32'd1);
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int bound, string name, output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < bound);
    check(name, {31'd0, busy}, 32'd0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x     = '0;
    cmd_if.cmd_y     = '0;
    cmd_if.cmd_w     = '0;
    cmd_if.cmd_h     = '0;
    cmd_if.cmd_color = '0;

    #2;
    check("rst_x", {24'd0, x}, 32'd0);
    check("rst_y", {25'd0, y}, 32'd0);
    check("rst_color", {29'd0, color}, 32'd0);
    check("rst_plot", {31'd0, plot}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Single 3x2 rectangle, latency and busy fall timing
    p0 = plot_cnt;
    exp_q.push_back(px(10, 20, 5)); exp_q.push_back(px(11, 20, 5));
    exp_q.push_back(px(12, 20, 5)); exp_q.push_back(px(10, 21, 5));
    exp_q.push_back(px(11, 21, 5)); exp_q.push_back(px(12, 21, 5));
    send(10, 20, 3, 2, 5, 1'b0);
    @(negedge clk);
    check("lat_e0_plot", {31'd0, plot}, 32'd0);
    check("lat_e0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_e1_plot", {31'd0, plot}, 32'd1);
    wait_idle(100, "single_busy_fall", t);
    check("single_busy_fall_cycles", t, 32'd6);
    check("single_count", plot_cnt - p0, 32'd6);
    check("single_run", last_run, 32'd6);
    check("single_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Clipping at the bottom-right corner
    p0 = plot_cnt;
    exp_q.push_back(px(158, 118, 2)); exp_q.push_back(px(159, 118, 2));
    exp_q.push_back(px(158, 119, 2)); exp_q.push_back(px(159, 119, 2));
    send(158, 118, 5, 5, 2, 1'b0);
    wait_idle(100, "clip_idle", t);
    check("clip_count", plot_cnt - p0, 32'd4);

    // Degenerate commands are silently discarded
    p0 = plot_cnt;
    exp_q.push_back(px(0, 0, 7));
    send(5, 5, 0, 3, 1, 1'b0);
    send(160, 5, 2, 2, 3, 1'b0);
    send(0, 0, 1, 1, 7, 1'b0);
    wait_idle(100, "degen_idle", t);
    check("degen_count", plot_cnt - p0, 32'd1);
    check("degen_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Back-pressure with valid held across four 4x4 commands
    p0 = plot_cnt;
    expect_rect(20, 30, 4, 4, 1);
    expect_rect(40, 50, 4, 4, 2);
    expect_rect(60, 70, 4, 4, 3);
    expect_rect(100, 10, 4, 4, 4);
    send(20, 30, 4, 4, 1, 1'b1);
    send(40, 50, 4, 4, 2, 1'b1);
    send(60, 70, 4, 4, 3, 1'b1);
    @(negedge clk);
    check("bp_ready_full", {31'd0, cmd_if.cmd_ready}, 32'd0);
    send(100, 10, 4, 4, 4, 1'b0);
    wait_idle(300, "bp_idle", t);
    check("bp_count", plot_cnt - p0, 32'd64);
    check("bp_run", last_run, 32'd64);
    check("bp_last_x", {24'd0, x}, 32'd103);
    check("bp_last_y", {25'd0, y}, 32'd13);

    // Reset during the third pixel of a 4x4 with another queued
    p0 = plot_cnt;
    expect_rect(5, 5, 4, 4, 6);
    expect_rect(30, 30, 2, 2, 1);
    send(5, 5, 4, 4, 6, 1'b1);
    send(30, 30, 2, 2, 1, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(plot && x == 8'd7 && y == 7'd5) && t < 50);
    check("rst_mid_third_px", {31'd0, plot}, 32'd1);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_plot", {31'd0, plot}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    p0 = plot_cnt;
    repeat (30) @(negedge clk);
    check("rst_after_plots", plot_cnt - p0, 32'd0);
    check("rst_after_busy", {31'd0, busy}, 32'd0);
    check("rst_after_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Full screen fill
    p0 = plot_cnt;
    expect_rect(0, 0, 160, 120, 0);
    send(0, 0, 160, 120, 0, 1'b0);
    wait_idle(20000, "full_idle", t);
    check("full_count", plot_cnt - p0, 32'd19200);
    check("full_run", last_run, 32'd19200);
    check("full_last_x", {24'd0, x}, 32'd159);
    check("full_last_y", {25'd0, y}, 32'd119);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
